dlx_mem_arbiter: RTL and testbench

Two-master arbiter and sequencer for the single-port read/write memory model in the DLX test bench. It shares one memory port between the instruction-fetch requester (m0) and the load/store requester (m1). Each transaction is a request/done handshake, and the two masters are served round-robin. A watchdog flags any memory access that never completes. The block sits between the DLX core's memory-side ports and the rw memory interface.

---
 rtl/dlx_mem_arbiter_if.sv | 50 +++++
 rtl/dlx_mem_arbiter.sv | 107 ++++++++++
 tb/tb_dlx_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dlx_mem_arbiter_if.sv
// DLX memory-side bus: two requester channels (m0 fetch, m1 load/store) and the shared rw memory port.
// The arbiter takes the slave view; whoever drives requests and models the memory takes the master view.
interface dlx_mem_arbiter_if #(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16
);
    logic                    m0_req;
    logic                    m0_rnw;
    logic [ADDRESS_SIZE-1:0] m0_addr;
    logic [WORD_SIZE-1:0]    m0_wdata;
    logic                    m0_gnt;
    logic                    m0_done;
    logic [WORD_SIZE-1:0]    m0_rdata;

    logic                    m1_req;
    logic                    m1_rnw;
    logic [ADDRESS_SIZE-1:0] m1_addr;
    logic [WORD_SIZE-1:0]    m1_wdata;
    logic                    m1_gnt;
    logic                    m1_done;
    logic [WORD_SIZE-1:0]    m1_rdata;

    logic                    mem_enable;
    logic                    mem_rnw;
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0]    mem_wdata;
    logic [WORD_SIZE-1:0]    mem_rdata;
    logic                    mem_ready;
    logic                    timeout_err;

    modport slave (
        input  m0_req, m0_rnw, m0_addr, m0_wdata,
        input  m1_req, m1_rnw, m1_addr, m1_wdata,
        input  mem_rdata, mem_ready,
        output m0_gnt, m0_done, m0_rdata,
        output m1_gnt, m1_done, m1_rdata,
        output mem_enable, mem_rnw, mem_addr, mem_wdata,
        output timeout_err
    );

    modport master (
        output m0_req, m0_rnw, m0_addr, m0_wdata,
        output m1_req, m1_rnw, m1_addr, m1_wdata,
        output mem_rdata, mem_ready,
        input  m0_gnt, m0_done, m0_rdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  mem_enable, mem_rnw, mem_addr, mem_wdata,
        input  timeout_err
    );
endinterface

// File: rtl/dlx_mem_arbiter.sv
// Round-robin two-master sequencer for the DLX single-port rw memory model.
// Each access runs IDLE -> ISSUE -> WAIT -> RESP; a watchdog aborts accesses that never see mem_ready.
module dlx_mem_arbiter #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned ADDRESS_SIZE   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic              clk,
    input logic              rst,
    dlx_mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic             owner;       // 0 = m0, 1 = m1
    logic             last_grant;  // 0 = m0, 1 = m1
    logic [CNT_W-1:0] wait_cnt;

    logic                 pick_m1_c;
    logic [CNT_W-1:0]     cnt_next_c;
    logic                 expired_c;
    logic [WORD_SIZE-1:0] resp_data_c;

    // m1 wins when it is alone, or when both request and m0 held the last grant
    always_comb begin
        pick_m1_c   = bus.m1_req && (!bus.m0_req || !last_grant);
        cnt_next_c  = wait_cnt + CNT_W'(1);
        expired_c   = (cnt_next_c == TIMEOUT_LIMIT);
        resp_data_c = bus.mem_ready ? bus.mem_rdata : '1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            wait_cnt        <= '0;
            bus.mem_enable  <= 1'b0;
            bus.mem_rnw     <= 1'b1;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.m0_gnt      <= 1'b0;
            bus.m1_gnt      <= 1'b0;
            bus.m0_done     <= 1'b0;
            bus.m1_done     <= 1'b0;
            bus.m0_rdata    <= '0;
            bus.m1_rdata    <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        owner          <= pick_m1_c;
                        bus.mem_enable <= 1'b1;
                        bus.mem_rnw    <= pick_m1_c ? bus.m1_rnw   : bus.m0_rnw;
                        bus.mem_addr   <= pick_m1_c ? bus.m1_addr  : bus.m0_addr;
                        bus.mem_wdata  <= pick_m1_c ? bus.m1_wdata : bus.m0_wdata;
                        bus.m0_gnt     <= !pick_m1_c;
                        bus.m1_gnt     <= pick_m1_c;
                        state          <= ISSUE;
                    end
                end

                ISSUE: begin
                    bus.mem_enable <= 1'b0;
                    bus.m0_gnt     <= 1'b0;
                    bus.m1_gnt     <= 1'b0;
                    last_grant     <= owner;
                    wait_cnt       <= '0;
                    state          <= WAIT;
                end

                // mem_ready is only trusted here; a level left over from an earlier access is ignored
                WAIT: begin
                    if (!bus.mem_ready) begin
                        wait_cnt <= cnt_next_c;
                    end
                    if (bus.mem_ready || expired_c) begin
                        bus.m0_done  <= !owner;
                        bus.m1_done  <= owner;
                        bus.m0_rdata <= owner ? '0 : resp_data_c;
                        bus.m1_rdata <= owner ? resp_data_c : '0;
                        if (!bus.mem_ready) begin
                            bus.timeout_err <= 1'b1;
                        end
                        state <= RESP;
                    end
                end

                // Park the port as a read so the core does not drive the shared data bus while idle
                RESP: begin
                    bus.m0_done  <= 1'b0;
                    bus.m1_done  <= 1'b0;
                    bus.m0_rdata <= '0;
                    bus.m1_rdata <= '0;
                    bus.mem_rnw  <= 1'b1;
                    state        <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// Directed bench for dlx_mem_arbiter: round-robin, read/write, stale ready, watchdog and mid-access reset.
module tb_dlx_mem_arbiter;
    localparam int unsigned WORD_SIZE      = 32;
    localparam int unsigned ADDRESS_SIZE   = 16;
    localparam int unsigned TIMEOUT_CYCLES = 4;

    logic clk;
    logic rst;
    logic load_mem;
    int   n_checks;
    int   n_fail;

    logic [WORD_SIZE-1:0] mem_model [256];

    dlx_mem_arbiter_if #(.WORD_SIZE(WORD_SIZE), .ADDRESS_SIZE(ADDRESS_SIZE)) bus ();

    dlx_mem_arbiter #(
        .WORD_SIZE     (WORD_SIZE),
        .ADDRESS_SIZE  (ADDRESS_SIZE),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory stand-in: preloaded words, writes land on an ISSUE cycle with rnw low
    always @(posedge clk) begin
        if (load_mem) begin
            mem_model[8'h10] <= 32'hDEADBEEF;
            mem_model[8'h04] <= 32'h0BADF00D;
        end else if (bus.mem_enable && !bus.mem_rnw) begin
            mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem_model[bus.mem_addr[7:0]];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit m, input logic rnw, input logic [ADDRESS_SIZE-1:0] addr,
                           input logic [WORD_SIZE-1:0] wdata);
        if (!m) begin
            bus.m0_req = 1'b1; bus.m0_rnw = rnw; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end else begin
            bus.m1_req = 1'b1; bus.m1_rnw = rnw; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_mem_enable"},  64'(bus.mem_enable),  64'd0);
        check({p, "_mem_rnw"},     64'(bus.mem_rnw),     64'd1);
        check({p, "_mem_addr"},    64'(bus.mem_addr),    64'd0);
        check({p, "_mem_wdata"},   64'(bus.mem_wdata),   64'd0);
        check({p, "_m0_gnt"},      64'(bus.m0_gnt),      64'd0);
        check({p, "_m1_gnt"},      64'(bus.m1_gnt),      64'd0);
        check({p, "_m0_done"},     64'(bus.m0_done),     64'd0);
        check({p, "_m1_done"},     64'(bus.m1_done),     64'd0);
        check({p, "_m0_rdata"},    64'(bus.m0_rdata),    64'd0);
        check({p, "_m1_rdata"},    64'(bus.m1_rdata),    64'd0);
        check({p, "_timeout_err"}, 64'(bus.timeout_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        load_mem = 1'b1;
        bus.m0_req = 1'b0; bus.m0_rnw = 1'b1; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_rnw = 1'b1; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.mem_ready = 1'b0;

        step();
        check_reset("por");
        step();
        rst      = 1'b0;
        load_mem = 1'b0;
        step();

        // Round-robin: both requesting, m0 wins the first tie out of reset
        bus.mem_ready = 1'b1;
        set_req(1'b0, 1'b1, 16'h0010, 32'h0);
        set_req(1'b1, 1'b1, 16'h0004, 32'h0);
        step();
        check("rr1_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        check("rr1_m1_gnt", 64'(bus.m1_gnt), 64'd0);
        step();
        step();
        check("rr1_m0_done",  64'(bus.m0_done),  64'd1);
        check("rr1_m0_rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
        check("rr1_m1_done",  64'(bus.m1_done),  64'd0);
        check("rr1_m1_rdata", 64'(bus.m1_rdata), 64'd0);
        bus.m0_req = 1'b0;
        step();
        check("rr1_idle_m0_done", 64'(bus.m0_done), 64'd0);
        bus.m0_req = 1'b1;
        step();
        check("rr2_m1_gnt", 64'(bus.m1_gnt), 64'd1);
        check("rr2_m0_gnt", 64'(bus.m0_gnt), 64'd0);
        step();
        step();
        check("rr2_m1_done",  64'(bus.m1_done),  64'd1);
        check("rr2_m1_rdata", 64'(bus.m1_rdata), 64'h0BADF00D);
        check("rr2_m0_rdata", 64'(bus.m0_rdata), 64'd0);
        bus.m1_req = 1'b0;
        step();
        bus.m1_req = 1'b1;
        step();
        check("rr3_m0_gnt", 64'(bus.m0_gnt), 64'd1);
        check("rr3_m1_gnt", 64'(bus.m1_gnt), 64'd0);
        step();
        step();
        check("rr3_m0_done", 64'(bus.m0_done), 64'd1);
        bus.m0_req = 1'b0;
        step();
        step();
        check("rr4_m1_gnt", 64'(bus.m1_gnt), 64'd1);
        step();
        step();
        check("rr4_m1_done", 64'(bus.m1_done), 64'd1);
        bus.m1_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // Single read, ready in the second WAIT cycle
        set_req(1'b0, 1'b1, 16'h0010, 32'h0);
        step();
        check("rd_m0_gnt",     64'(bus.m0_gnt),     64'd1);
        check("rd_m1_gnt",     64'(bus.m1_gnt),     64'd0);
        check("rd_mem_enable", 64'(bus.mem_enable), 64'd1);
        check("rd_mem_rnw",    64'(bus.mem_rnw),    64'd1);
        check("rd_mem_addr",   64'(bus.mem_addr),   64'h0010);
        step();
        check("rd_w1_done",   64'(bus.m0_done),    64'd0);
        check("rd_w1_enable", 64'(bus.mem_enable), 64'd0);
        check("rd_w1_addr",   64'(bus.mem_addr),   64'h0010);
        step();
        check("rd_w2_done", 64'(bus.m0_done), 64'd0);
        bus.mem_ready = 1'b1;
        step();
        check("rd_m0_done",  64'(bus.m0_done),  64'd1);
        check("rd_m0_rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
        check("rd_m1_done",  64'(bus.m1_done),  64'd0);
        check("rd_m1_rdata", 64'(bus.m1_rdata), 64'd0);
        bus.m0_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();
        check("rd_idle_done",  64'(bus.m0_done),  64'd0);
        check("rd_idle_rdata", 64'(bus.m0_rdata), 64'd0);

        // m1 write
        set_req(1'b1, 1'b0, 16'h0004, 32'h12345678);
        step();
        check("wr_m1_gnt",     64'(bus.m1_gnt),     64'd1);
        check("wr_mem_enable", 64'(bus.mem_enable), 64'd1);
        check("wr_mem_rnw",    64'(bus.mem_rnw),    64'd0);
        check("wr_mem_addr",   64'(bus.mem_addr),   64'h0004);
        check("wr_mem_wdata",  64'(bus.mem_wdata),  64'h12345678);
        bus.mem_ready = 1'b1;
        step();
        step();
        check("wr_m1_done", 64'(bus.m1_done), 64'd1);
        bus.m1_req = 1'b0;
        step();

        // Read-back with mem_ready left high from the write: completion only after WAIT
        set_req(1'b0, 1'b1, 16'h0004, 32'h0);
        step();
        check("stale_issue_done", 64'(bus.m0_done), 64'd0);
        step();
        check("stale_wait_done", 64'(bus.m0_done), 64'd0);
        step();
        check("stale_m0_done",  64'(bus.m0_done),  64'd1);
        check("stale_m0_rdata", 64'(bus.m0_rdata), 64'h12345678);
        bus.m0_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // Watchdog: no ready, done TIMEOUT_CYCLES+1 cycles after ISSUE
        set_req(1'b0, 1'b1, 16'h0010, 32'h0);
        step();
        check("to_issue_err", 64'(bus.timeout_err), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("to_w%0d_done", i), 64'(bus.m0_done), 64'd0);
        end
        step();
        check("to_m0_done",  64'(bus.m0_done),     64'd1);
        check("to_m0_rdata", 64'(bus.m0_rdata),    64'hFFFFFFFF);
        check("to_err",      64'(bus.timeout_err), 64'd1);
        bus.m0_req = 1'b0;
        step();
        check("to_err_idle", 64'(bus.timeout_err), 64'd1);
        bus.mem_ready = 1'b1;
        set_req(1'b1, 1'b1, 16'h0004, 32'h0);
        step();
        step();
        step();
        check("to_good_done",  64'(bus.m1_done),     64'd1);
        check("to_good_rdata", 64'(bus.m1_rdata),    64'h12345678);
        check("to_err_sticky", 64'(bus.timeout_err), 64'd1);
        bus.m1_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        // Reset while in WAIT drops the access
        set_req(1'b0, 1'b0, 16'h0020, 32'h00000055);
        step();
        step();
        rst = 1'b1;
        step();
        check_reset("rst_wait");
        rst        = 1'b0;
        bus.m0_req = 1'b0;
        step();
        check("rst_no_done_a", 64'(bus.m0_done), 64'd0);
        step();
        check("rst_no_done_b", 64'(bus.m0_done), 64'd0);
        bus.mem_ready = 1'b1;
        set_req(1'b1, 1'b1, 16'h0004, 32'h0);
        step();
        check("post_rst_m1_gnt", 64'(bus.m1_gnt), 64'd1);
        step();
        step();
        check("post_rst_m1_done",  64'(bus.m1_done),     64'd1);
        check("post_rst_m1_rdata", 64'(bus.m1_rdata),    64'h12345678);
        check("post_rst_err",      64'(bus.timeout_err), 64'd0);
        bus.m1_req    = 1'b0;
        bus.mem_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
